// File: rtl/rmt_egress_sf_buffer_pkg.sv
// Shared definitions for the RMT egress store-and-forward buffer.
// The beat layout is {tdata, tuser, tkeep, tlast}, with tlast in bit 0. The deparser
// packet FIFO uses the same layout, so a stored beat can be sliced with the same
// offsets on both sides.
package rmt_egress_sf_buffer_pkg;

    localparam int DEF_DATA_WIDTH  = 512;
    localparam int DEF_TUSER_WIDTH = 128;
    localparam int DEF_DEPTH_LOG2  = 6;

    function automatic int beat_width(input int data_w, input int tuser_w);
        return data_w + tuser_w + data_w / 8 + 1;
    endfunction

    // Field offsets inside a packed beat
    localparam int OFF_LAST = 0;
    localparam int OFF_KEEP = 1;

    function automatic int tuser_offset(input int data_w);
        return 1 + data_w / 8;
    endfunction

    function automatic int tdata_offset(input int data_w, input int tuser_w);
        return 1 + data_w / 8 + tuser_w;
    endfunction

    localparam int BEAT_W = beat_width(DEF_DATA_WIDTH, DEF_TUSER_WIDTH);  // 705

    typedef enum logic [1:0] {WR_IDLE, WR_PKT, WR_DROP} wr_state_t;
    typedef enum logic       {RD_IDLE, RD_PKT}          rd_state_t;

endpackage

// File: rtl/rmt_egress_sf_buffer_sf_buf_ram.sv
// Simple dual-port beat store: one write port, one read port with a registered
// 1-cycle read. No reset on the array or the read register so it maps onto block RAM.
// Ports:
//   clk              clock
//   wr_en/wr_addr    write strobe and address, wr_data written on the rising edge
//   rd_en/rd_addr    read strobe and address, rd_data valid the cycle after rd_en
module sf_buf_ram #(
    parameter int WIDTH  = 705,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/rmt_egress_sf_buffer.sv
// Store-and-forward egress buffer behind the RMT deparser. A packet becomes visible
// to the read side only once its tlast beat is stored, so the whole packet can then be
// streamed with no tvalid bubbles. The deparser is never back-pressured: a packet that
// does not fit is dropped whole and counted.
// Ports:
//   clk, aresetn        clock, asynchronous active-low reset
//   s_axis_*            input stream from the deparser (s_axis_tready is 1 out of reset)
//   m_axis_*            output stream towards the MAC TX, all outputs registered
//   drop_pkt_cnt        saturating count of packets dropped on overflow
//   stored_pkts         complete packets held and not yet fully emitted
module rmt_egress_sf_buffer
    import rmt_egress_sf_buffer_pkg::*;
#(
    parameter int C_S_AXIS_DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int C_S_AXIS_TUSER_WIDTH = DEF_TUSER_WIDTH,
    parameter int DEPTH_LOG2           = DEF_DEPTH_LOG2
) (
    input  logic                              clk,
    input  logic                              aresetn,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
    input  logic                              s_axis_tvalid,
    output logic                              s_axis_tready,
    input  logic                              s_axis_tlast,
    output logic [C_S_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
    output logic [C_S_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
    output logic                              m_axis_tvalid,
    input  logic                              m_axis_tready,
    output logic                              m_axis_tlast,
    output logic [31:0]                       drop_pkt_cnt,
    output logic [DEPTH_LOG2:0]               stored_pkts
);

    localparam int DW       = C_S_AXIS_DATA_WIDTH;
    localparam int UW       = C_S_AXIS_TUSER_WIDTH;
    localparam int KW       = DW / 8;
    localparam int BW       = beat_width(DW, UW);
    localparam int PW       = DEPTH_LOG2 + 1;
    localparam int OFF_USER = tuser_offset(DW);
    localparam int OFF_DATA = tdata_offset(DW, UW);
    localparam logic [PW-1:0] DEPTH = {1'b1, {DEPTH_LOG2{1'b0}}};

    wr_state_t     wr_state_reg;
    rd_state_t     rd_state_reg;
    logic [PW-1:0] wr_ptr_reg;
    logic [PW-1:0] wr_commit_reg;
    logic [PW-1:0] rd_ptr_reg;       // RAM fetch pointer; slots behind it are free
    logic [PW-1:0] stored_reg;
    logic [31:0]   drop_cnt_reg;
    logic          ready_reg;
    logic          rd_inflight_reg;  // RAM read issued last cycle, data on ram_rd_data now
    logic          out_valid_reg;
    logic [BW-1:0] out_beat_reg;
    logic          skid_valid_reg;
    logic [BW-1:0] skid_beat_reg;

    logic [BW-1:0] in_beat;
    logic [BW-1:0] ram_rd_data;
    logic [PW-1:0] used;
    logic          full;
    logic          wr_en;
    logic          commit;
    logic          pop;
    logic          pop_last;
    logic [1:0]    fill_after_pop;
    logic          rd_en;

    assign in_beat = {s_axis_tdata, s_axis_tuser, s_axis_tkeep, s_axis_tlast};
    assign used    = wr_ptr_reg - rd_ptr_reg;
    assign full    = (used == DEPTH);
    assign wr_en   = s_axis_tvalid && (wr_state_reg != WR_DROP) && !full;
    assign commit  = wr_en && s_axis_tlast;

    assign pop      = out_valid_reg && m_axis_tready;
    assign pop_last = pop && out_beat_reg[OFF_LAST];

    // Output register + skid + one in-flight read never exceed two beats, which keeps
    // one beat per cycle flowing across the RAM read latency without overrunning the skid.
    assign fill_after_pop = 2'(out_valid_reg) + 2'(skid_valid_reg) + 2'(rd_inflight_reg) - 2'(pop);
    assign rd_en          = (rd_ptr_reg != wr_commit_reg) && (fill_after_pop <= 2'd1);

    sf_buf_ram #(
        .WIDTH  (BW),
        .ADDR_W (DEPTH_LOG2)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr_reg[DEPTH_LOG2-1:0]),
        .wr_data (in_beat),
        .rd_en   (rd_en),
        .rd_addr (rd_ptr_reg[DEPTH_LOG2-1:0]),
        .rd_data (ram_rd_data)
    );

    // Write FSM: store beats, commit on tlast, rewind to the last commit on overflow.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            wr_state_reg  <= WR_IDLE;
            wr_ptr_reg    <= '0;
            wr_commit_reg <= '0;
            drop_cnt_reg  <= '0;
            ready_reg     <= 1'b0;
        end else begin
            ready_reg <= 1'b1;
            case (wr_state_reg)
                WR_IDLE, WR_PKT: begin
                    if (s_axis_tvalid) begin
                        if (!full) begin
                            wr_ptr_reg <= wr_ptr_reg + 1'b1;
                            if (s_axis_tlast) begin
                                wr_commit_reg <= wr_ptr_reg + 1'b1;
                                wr_state_reg  <= WR_IDLE;
                            end else begin
                                wr_state_reg  <= WR_PKT;
                            end
                        end else begin
                            wr_ptr_reg <= wr_commit_reg;
                            if (drop_cnt_reg != 32'hFFFF_FFFF) begin
                                drop_cnt_reg <= drop_cnt_reg + 32'd1;
                            end
                            wr_state_reg <= s_axis_tlast ? WR_IDLE : WR_DROP;
                        end
                    end
                end
                WR_DROP: begin
                    if (s_axis_tvalid && s_axis_tlast) begin
                        wr_state_reg <= WR_IDLE;
                    end
                end
                default: wr_state_reg <= WR_IDLE;
            endcase
        end
    end

    // Commit and final read in the same cycle cancel out.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            stored_reg <= '0;
        end else if (commit && !pop_last) begin
            stored_reg <= stored_reg + 1'b1;
        end else if (!commit && pop_last) begin
            stored_reg <= stored_reg - 1'b1;
        end
    end

    // Read FSM with prefetch: the output register is refilled from the skid first,
    // then straight from the RAM, so data order is preserved.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            rd_state_reg    <= RD_IDLE;
            rd_ptr_reg      <= '0;
            rd_inflight_reg <= 1'b0;
            out_valid_reg   <= 1'b0;
            out_beat_reg    <= '0;
            skid_valid_reg  <= 1'b0;
            skid_beat_reg   <= '0;
        end else begin
            rd_inflight_reg <= rd_en;
            if (rd_en) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end

            if (!out_valid_reg || pop) begin
                if (skid_valid_reg) begin
                    out_valid_reg  <= 1'b1;
                    out_beat_reg   <= skid_beat_reg;
                    skid_valid_reg <= rd_inflight_reg;
                    if (rd_inflight_reg) begin
                        skid_beat_reg <= ram_rd_data;
                    end
                end else if (rd_inflight_reg) begin
                    out_valid_reg <= 1'b1;
                    out_beat_reg  <= ram_rd_data;
                end else begin
                    out_valid_reg <= 1'b0;
                end
            end else if (rd_inflight_reg) begin
                skid_valid_reg <= 1'b1;
                skid_beat_reg  <= ram_rd_data;
            end

            case (rd_state_reg)
                RD_IDLE: begin
                    if (rd_inflight_reg) begin
                        rd_state_reg <= RD_PKT;
                    end
                end
                RD_PKT: begin
                    // Stay busy back-to-back while the next packet's head is already queued.
                    if (pop_last && !skid_valid_reg && !rd_inflight_reg) begin
                        rd_state_reg <= RD_IDLE;
                    end
                end
                default: rd_state_reg <= RD_IDLE;
            endcase
        end
    end

    assign s_axis_tready = ready_reg;
    assign m_axis_tvalid = out_valid_reg;
    assign m_axis_tlast  = out_beat_reg[OFF_LAST];
    assign m_axis_tkeep  = out_beat_reg[OFF_KEEP +: KW];
    assign m_axis_tuser  = out_beat_reg[OFF_USER +: UW];
    assign m_axis_tdata  = out_beat_reg[OFF_DATA +: DW];
    assign drop_pkt_cnt  = drop_cnt_reg;
    assign stored_pkts   = stored_reg;

endmodule

// File: tb/tb_rmt_egress_sf_buffer.sv
// Directed bench for rmt_egress_sf_buffer: ordering/bit-exactness, store-and-forward
// latency, overflow drops, back-pressure, randomised tready, and asynchronous reset.
module tb_rmt_egress_sf_buffer;
    import rmt_egress_sf_buffer_pkg::*;

    localparam int DW = 512;
    localparam int UW = 128;
    localparam int KW = 64;
    localparam int L2 = 6;
    localparam int BW = DW + UW + KW + 1;

    logic          clk;
    logic          aresetn;
    logic [DW-1:0] s_tdata;
    logic [KW-1:0] s_tkeep;
    logic [UW-1:0] s_tuser;
    logic          s_tvalid;
    logic          s_tready;
    logic          s_tlast;
    logic [DW-1:0] m_tdata;
    logic [KW-1:0] m_tkeep;
    logic [UW-1:0] m_tuser;
    logic          m_tvalid;
    logic          m_tready;
    logic          m_tlast;
    logic [31:0]   drop_cnt;
    logic [L2:0]   stored;

    rmt_egress_sf_buffer dut (
        .clk           (clk),
        .aresetn       (aresetn),
        .s_axis_tdata  (s_tdata),
        .s_axis_tkeep  (s_tkeep),
        .s_axis_tuser  (s_tuser),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .s_axis_tlast  (s_tlast),
        .m_axis_tdata  (m_tdata),
        .m_axis_tkeep  (m_tkeep),
        .m_axis_tuser  (m_tuser),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .m_axis_tlast  (m_tlast),
        .drop_pkt_cnt  (drop_cnt),
        .stored_pkts   (stored)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check_val(input string tag, input logic [767:0] obs, input logic [767:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    logic [BW-1:0] exp_q[$];
    int  n_committed = 0;
    int  n_emitted   = 0;
    bit  rand_ready  = 1'b0;

    function automatic logic [BW-1:0] make_beat(input int id, input int b, input int len);
        logic [DW-1:0] d;
        logic [UW-1:0] u;
        logic [KW-1:0] k;
        logic [31:0]   w;
        logic          last;
        w    = {id[15:0], b[15:0]};
        last = (b == len - 1);
        for (int i = 0; i < 16; i++) d[i*32 +: 32] = w + 32'(i) * 32'h0101_0101;
        u = {id ^ 32'hDEAD_BEEF, len, w, ~w};
        k = last ? (64'hFFFF_FFFF_FFFF_FFFF >> (id % 64)) : {KW{1'b1}};
        return {d, u, k, last};
    endfunction

    // Drives one packet starting at posedge+1; returns at posedge+1 after the last beat
    // (plus gap). keep=0 means the packet must be dropped by the DUT.
    task automatic send_pkt(input int id, input int len, input int gap, input bit keep, input bit quiet);
        logic [BW-1:0] bt;
        for (int b = 0; b < len; b++) begin
            bt = make_beat(id, b, len);
            {s_tdata, s_tuser, s_tkeep, s_tlast} = bt;
            s_tvalid = 1'b1;
            if (keep) exp_q.push_back(bt);
            @(posedge clk); #1;
            s_tvalid = 1'b0;
            if (quiet) check_val("no_early_out", m_tvalid, 1'b0);
            if (b == len - 1 && keep) n_committed++;
            for (int g = 0; g < gap; g++) begin
                @(posedge clk); #1;
            end
        end
        if (!keep) $display("in  pkt id=%0d len=%0d sent, expected drop", id, len);
    endtask

    task automatic wait_drain(input int max_cyc);
        for (int i = 0; i < max_cyc; i++) begin
            if (exp_q.size() == 0 && stored == 0 && !m_tvalid) break;
            @(posedge clk); #1;
        end
        check_val("drain", (exp_q.size() == 0) && (stored == 0) && !m_tvalid, 1'b1);
    endtask

    task automatic check_reset_outputs();
        check_val("rst_s_tready", s_tready, 1'b0);
        check_val("rst_m_tvalid", m_tvalid, 1'b0);
        check_val("rst_m_tlast",  m_tlast, 1'b0);
        check_val("rst_m_tdata",  m_tdata, '0);
        check_val("rst_m_tkeep",  m_tkeep, '0);
        check_val("rst_m_tuser",  m_tuser, '0);
        check_val("rst_drop",     drop_cnt, '0);
        check_val("rst_stored",   stored, '0);
    endtask

    task automatic flush_model();
        exp_q.delete();
        n_committed = 0;
        n_emitted   = 0;
    endtask

    // Monitor: scoreboard, no mid-packet gap, hold-while-stalled, stored bound
    logic [BW-1:0] prev_beat;
    bit            prev_stall = 1'b0;
    bit            in_pkt     = 1'b0;
    int            out_beats  = 0;

    always @(negedge clk) begin
        logic [BW-1:0] got;
        logic [BW-1:0] e;
        if (!aresetn) begin
            in_pkt     = 1'b0;
            prev_stall = 1'b0;
            out_beats  = 0;
        end else begin
            got = {m_tdata, m_tuser, m_tkeep, m_tlast};
            if (in_pkt) check_val("no_gap", m_tvalid, 1'b1);
            if (prev_stall) check_val("hold", got, prev_beat);
            check_val("stored_bound", int'(stored) <= (n_committed - n_emitted), 1'b1);
            if (m_tvalid && m_tready) begin
                check_val("beat_expected", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check_val("beat", got, e);
                end
                out_beats++;
                in_pkt = !m_tlast;
                if (m_tlast) begin
                    n_emitted++;
                    $display("out pkt #%0d beats=%0d id=%0d", n_emitted, out_beats,
                             32'(m_tuser[127:96] ^ 32'hDEAD_BEEF));
                    out_beats = 0;
                end
            end
            prev_stall = m_tvalid && !m_tready;
            prev_beat  = got;
        end
    end

    initial begin
        forever begin
            @(posedge clk); #1;
            if (rand_ready) m_tready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        int k;
        aresetn  = 1'b0;
        s_tvalid = 1'b0;
        s_tdata  = '0;
        s_tkeep  = '0;
        s_tuser  = '0;
        s_tlast  = 1'b0;
        m_tready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs();
        aresetn = 1'b1;
        @(posedge clk); #1;
        check_val("ready_after_rst", s_tready, 1'b1);

        // 1, 4, 9 beats back to back
        send_pkt(1, 1, 0, 1'b1, 1'b0);
        send_pkt(2, 4, 0, 1'b1, 1'b0);
        send_pkt(3, 9, 0, 1'b1, 1'b0);
        wait_drain(200);
        check_val("t1_drop", drop_cnt, 32'd0);

        // 20 beats with idle cycles: nothing out before tlast, then contiguous
        send_pkt(4, 20, 1, 1'b1, 1'b1);
        k = 0;
        for (int i = 1; i <= 20; i++) begin
            k = i;
            if (m_tvalid) break;
            @(posedge clk); #1;
        end
        check_val("t2_latency", (k >= 2) && (k <= 10), 1'b1);
        wait_drain(200);

        // oversized packet dropped, following short one intact
        send_pkt(5, 70, 0, 1'b0, 1'b0);
        check_val("t3_drop", drop_cnt, 32'd1);
        send_pkt(6, 2, 0, 1'b1, 1'b0);
        wait_drain(200);
        check_val("t3_drop_after", drop_cnt, 32'd1);

        // 60 beats buffered under back-pressure, then a 10-beat packet overflows
        m_tready = 1'b0;
        for (int p = 0; p < 6; p++) send_pkt(10 + p, 10, 0, 1'b1, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        check_val("t4_stored6", stored, 7'd6);
        send_pkt(16, 10, 0, 1'b0, 1'b0);
        check_val("t4_drop", drop_cnt, 32'd2);
        check_val("t4_stored_after", stored, 7'd6);
        m_tready = 1'b1;
        wait_drain(400);
        check_val("t4_stored0", stored, 7'd0);

        // reset in the middle of a write, with a committed packet held
        m_tready = 1'b0;
        send_pkt(20, 3, 0, 1'b1, 1'b0);
        for (int b = 0; b < 3; b++) begin
            {s_tdata, s_tuser, s_tkeep, s_tlast} = make_beat(21, b, 8);
            s_tvalid = 1'b1;
            @(posedge clk); #1;
        end
        #2;
        aresetn = 1'b0;
        #1;
        s_tvalid = 1'b0;
        check_reset_outputs();
        flush_model();
        m_tready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        aresetn = 1'b1;
        @(posedge clk); #1;
        send_pkt(22, 5, 0, 1'b1, 1'b0);
        wait_drain(200);

        // reset in the middle of a read
        send_pkt(23, 30, 0, 1'b1, 1'b0);
        k = 0;
        for (int i = 0; i < 50; i++) begin
            if (m_tvalid) break;
            k = i + 1;
            @(posedge clk); #1;
        end
        check_val("t6_started", m_tvalid, 1'b1);
        repeat (5) @(posedge clk);
        #3;
        aresetn = 1'b0;
        #1;
        check_reset_outputs();
        flush_model();
        repeat (2) @(posedge clk);
        #1;
        aresetn = 1'b1;
        @(posedge clk); #1;
        send_pkt(24, 3, 0, 1'b1, 1'b0);
        wait_drain(200);

        // randomised tready over many short packets
        rand_ready = 1'b1;
        for (int p = 0; p < 1000; p++) begin
            for (int i = 0; i < 500; i++) begin
                if (stored <= 2) break;
                @(posedge clk); #1;
            end
            check_val("space_wait", stored <= 2, 1'b1);
            send_pkt(100 + p, int'($urandom_range(1, 8)), ($urandom_range(0, 3) == 0) ? 1 : 0,
                     1'b1, 1'b0);
        end
        rand_ready = 1'b0;
        @(posedge clk); #1;
        m_tready = 1'b1;
        wait_drain(2000);
        check_val("t7_drop", drop_cnt, 32'd0);
        check_val("t7_emitted", n_emitted, n_committed);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
